// File: rtl/sipo_frame_cb.sv
// -----------------------------------------------------------------------------
// sipo_frame_cb
// Serial-in / parallel-out frame collector with a one-word output holding
// register and a valid/ready handshake.
//
// A frame is assembled from serial bits that are sampled on DAT_IN_CB while
// EN_CB is high. When the last bit of a frame arrives, the finished word is
// moved to DAT_OUT_CB. This transfer happens only if the holding register is
// free, or is being consumed on that same edge. Otherwise the frame is
// dropped and the sticky OVF_CB flag is set.
//
// Optional feature (macro SIPO_FRAME_CB_PARITY_EN):
//   undefined : a frame is WIDTH bits long and PAR_ERR_CB is held at 0.
//   defined   : a frame is WIDTH data bits followed by one even-parity bit.
//               The parity bit is not stored. PAR_ERR_CB is loaded together
//               with DAT_OUT_CB and is 1 when the data bits and the parity
//               bit together have odd parity.
//
// Parameters
//   WIDTH      parallel word width (2..1024)
//   LSB_FIRST  1: the first received bit ends up in bit 0
//              0: the first received bit ends up in bit WIDTH-1
//
// Ports
//   CLOCK_CB    in   clock; all state changes on the rising edge
//   RES_CB      in   asynchronous active-low reset; the integrator must
//                    synchronise its release
//   EN_CB       in   serial bit strobe
//   DAT_IN_CB   in   serial data bit
//   CLR_CB      in   synchronous frame restart; takes priority over EN_CB
//   READY_CB    in   consumer accepts DAT_OUT_CB
//   DAT_OUT_CB  out  registered parallel word
//   VALID_CB    out  DAT_OUT_CB holds a word that has not been consumed
//   OVF_CB      out  sticky flag: a frame was dropped
//   PAR_ERR_CB  out  parity error of the word in DAT_OUT_CB
//   BIT_CNT_CB  out  number of bits received so far in the current frame
// -----------------------------------------------------------------------------
module sipo_frame_cb #(
    parameter int WIDTH     = 112,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                          CLOCK_CB,
    input  logic                          RES_CB,
    input  logic                          EN_CB,
    input  logic                          DAT_IN_CB,
    input  logic                          CLR_CB,
    input  logic                          READY_CB,
    output logic [WIDTH-1:0]              DAT_OUT_CB,
    output logic                          VALID_CB,
    output logic                          OVF_CB,
    output logic                          PAR_ERR_CB,
    output logic [$clog2(WIDTH+2)-1:0]    BIT_CNT_CB
);

    localparam int CW = $clog2(WIDTH + 2);
`ifdef SIPO_FRAME_CB_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif
    localparam logic [CW-1:0] LAST_IDX  = CW'(FLEN - 1);
    localparam logic [CW-1:0] DATA_BITS = CW'(WIDTH);

    // Even-parity check: returns 1 when the data bits and the parity bit
    // together contain an odd number of ones.
    function automatic logic parity_err(input logic [WIDTH-1:0] data, input logic pbit);
        return (^data) ^ pbit;
    endfunction

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dat_out_q, dat_out_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             par_err_q, par_err_d;

    logic [WIDTH-1:0] shift_nxt_s;
    logic [WIDTH-1:0] word_s;
    logic             par_s;
    logic             capture_s;
    logic             last_s;
    logic             load_s;

    // Next-state logic for frame assembly, the output register and the flags.
    always_comb begin
        shift_nxt_s = shift_q;
        if (LSB_FIRST) begin
            shift_nxt_s = {DAT_IN_CB, shift_q[WIDTH-1:1]};
        end else begin
            shift_nxt_s = {shift_q[WIDTH-2:0], DAT_IN_CB};
        end

        // CLR_CB takes priority over the strobe, so no bit is taken on a clear edge.
        capture_s = EN_CB && !CLR_CB;
        last_s    = capture_s && (cnt_q == LAST_IDX);
        load_s    = last_s && (!valid_q || READY_CB);

`ifdef SIPO_FRAME_CB_PARITY_EN
        // The last bit is the parity bit: the data word is already complete.
        word_s = shift_q;
        par_s  = parity_err(shift_q, DAT_IN_CB);
`else
        // The last bit is a data bit and becomes part of the word.
        word_s = shift_nxt_s;
        par_s  = 1'b0;
`endif

        // Only data bits are shifted in; the parity bit is never stored.
        if (CLR_CB) begin
            shift_d = {WIDTH{1'b0}};
        end else if (capture_s && (cnt_q < DATA_BITS)) begin
            shift_d = shift_nxt_s;
        end else begin
            shift_d = shift_q;
        end

        if (CLR_CB) begin
            cnt_d = {CW{1'b0}};
        end else if (last_s) begin
            cnt_d = {CW{1'b0}};
        end else if (capture_s) begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end

        if (load_s) begin
            dat_out_d = word_s;
            par_err_d = par_s;
        end else begin
            dat_out_d = dat_out_q;
            par_err_d = par_err_q;
        end

        // A word loaded on the same edge as a consume keeps VALID_CB high.
        if (load_s) begin
            valid_d = 1'b1;
        end else if (valid_q && READY_CB) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        if (CLR_CB) begin
            ovf_d = 1'b0;
        end else if (last_s && !load_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge CLOCK_CB or negedge RES_CB) begin
        if (!RES_CB) begin
            shift_q   <= {WIDTH{1'b0}};
            cnt_q     <= {CW{1'b0}};
            dat_out_q <= {WIDTH{1'b0}};
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            dat_out_q <= dat_out_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            par_err_q <= par_err_d;
        end
    end

    assign DAT_OUT_CB = dat_out_q;
    assign VALID_CB   = valid_q;
    assign OVF_CB     = ovf_q;
    assign PAR_ERR_CB = par_err_q;
    assign BIT_CNT_CB = cnt_q;

endmodule

// File: tb/tb_sipo_frame_cb.sv
// -----------------------------------------------------------------------------
// tb_sipo_frame_cb
// Directed bench for sipo_frame_cb with WIDTH=8. It drives two instances from
// the same inputs: dut0 uses LSB_FIRST=1 and dut1 uses LSB_FIRST=0.
// Expected dut0 words are queued when a frame is sent and are compared when
// the word appears on DAT_OUT_CB. Inputs change and outputs are sampled on the
// falling edge of the clock.
// -----------------------------------------------------------------------------
module tb_sipo_frame_cb;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 2);
`ifdef SIPO_FRAME_CB_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          din;
    logic          clr;
    logic          ready;
    logic [W-1:0]  dat0, dat1;
    logic          valid0, valid1;
    logic          ovf0, ovf1;
    logic          par0, par1;
    logic [CW-1:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    sipo_frame_cb #(.WIDTH(W), .LSB_FIRST(1'b1)) dut0 (
        .CLOCK_CB(clk), .RES_CB(rst_n), .EN_CB(en), .DAT_IN_CB(din),
        .CLR_CB(clr), .READY_CB(ready), .DAT_OUT_CB(dat0), .VALID_CB(valid0),
        .OVF_CB(ovf0), .PAR_ERR_CB(par0), .BIT_CNT_CB(cnt0)
    );

    sipo_frame_cb #(.WIDTH(W), .LSB_FIRST(1'b0)) dut1 (
        .CLOCK_CB(clk), .RES_CB(rst_n), .EN_CB(en), .DAT_IN_CB(din),
        .CLR_CB(clr), .READY_CB(ready), .DAT_OUT_CB(dat1), .VALID_CB(valid1),
        .OVF_CB(ovf1), .PAR_ERR_CB(par1), .BIT_CNT_CB(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pop the next expected word and compare it with dut0's output.
    task automatic check_out(input string tag);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, dat0);
        end else begin
            check(tag, {24'h0, dat0}, {24'h0, exp_q.pop_front()});
        end
    endtask

    // Send one frame, bit 0 first. The parity bit is appended when parity is
    // enabled. READY is set to rdy_last for the edge that takes the last bit.
    // If do_chk is set, VALID is compared with exp_v before every bit.
    task automatic send_word(input logic [W-1:0] w, input logic pbit,
                             input logic rdy_last, input bit do_chk, input logic exp_v);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            if (do_chk) check("valid_during_frame", {31'h0, valid0}, {31'h0, exp_v});
            en  = 1'b1;
            din = w[i];
            if (i == W - 1 && !PAR) ready = rdy_last;
        end
        if (PAR) begin
            @(negedge clk);
            if (do_chk) check("valid_during_frame", {31'h0, valid0}, {31'h0, exp_v});
            en    = 1'b1;
            din   = pbit;
            ready = rdy_last;
        end
        @(negedge clk);
        en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; din = 1'b0; clr = 1'b0; ready = 1'b1;

        // Reset values.
        #2 rst_n = 1'b0;
        #1;
        check("rst_dat",   {24'h0, dat0}, 32'h0);
        check("rst_valid", {31'h0, valid0}, 32'h0);
        check("rst_ovf",   {31'h0, ovf0}, 32'h0);
        check("rst_par",   {31'h0, par0}, 32'h0);
        check("rst_cnt",   {28'h0, cnt0}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame: bit order for both settings; VALID rises only after the last bit.
        exp_q.push_back(8'h4D);
        send_word(8'h4D, ^8'h4D, 1'b1, 1'b1, 1'b0);
        check("lsb_valid", {31'h0, valid0}, 32'h1);
        check_out("lsb_dat_4d");
        check("msb_dat_b2", {24'h0, dat1}, 32'hB2);
        check("cnt_wrap", {28'h0, cnt0}, 32'h0);
        @(negedge clk);
        check("valid_consumed", {31'h0, valid0}, 32'h0);

        // Overflow: the second frame is dropped while the first is still held.
        ready = 1'b0;
        exp_q.push_back(8'h4D);
        send_word(8'h4D, ^8'h4D, 1'b0, 1'b0, 1'b0);
        check("hold_valid", {31'h0, valid0}, 32'h1);
        check_out("hold_dat_4d");
        check("hold_ovf0", {31'h0, ovf0}, 32'h0);
        send_word(8'hFF, ^8'hFF, 1'b0, 1'b0, 1'b0);
        check("ovf_dat_kept", {24'h0, dat0}, 32'h4D);
        check("ovf_valid", {31'h0, valid0}, 32'h1);
        check("ovf_set", {31'h0, ovf0}, 32'h1);
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        check("clr_ovf", {31'h0, ovf0}, 32'h0);
        check("clr_valid_kept", {31'h0, valid0}, 32'h1);

        // Consume and load on the same edge: VALID stays high throughout.
        exp_q.push_back(8'h0F);
        send_word(8'h0F, ^8'h0F, 1'b1, 1'b1, 1'b1);
        check("swap_valid", {31'h0, valid0}, 32'h1);
        check_out("swap_dat_0f");
        check("swap_ovf", {31'h0, ovf0}, 32'h0);
        @(negedge clk);
        check("swap_consumed", {31'h0, valid0}, 32'h0);

        // Restart a frame with CLR asserted while EN is also high.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); en = 1'b1; din = 1'b1;
        end
        @(negedge clk); en = 1'b1; din = 1'b1; clr = 1'b1;
        check("cnt_three", {28'h0, cnt0}, 32'h3);
        @(negedge clk); en = 1'b0; clr = 1'b0;
        check("clr_cnt", {28'h0, cnt0}, 32'h0);
        exp_q.push_back(8'hA5);
        send_word(8'hA5, ^8'hA5, 1'b1, 1'b0, 1'b0);
        check_out("after_clr_a5");
        @(negedge clk);

        // Asynchronous reset in the middle of a frame while VALID is high.
        ready = 1'b0;
        send_word(8'h4D, ^8'h4D, 1'b0, 1'b0, 1'b0);
        check("pre_rst_valid", {31'h0, valid0}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); en = 1'b1; din = 1'b1;
        end
        @(negedge clk); en = 1'b0;
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("arst_dat",   {24'h0, dat0}, 32'h0);
        check("arst_valid", {31'h0, valid0}, 32'h0);
        check("arst_cnt",   {28'h0, cnt0}, 32'h0);
        check("arst_ovf",   {31'h0, ovf0}, 32'h0);
        @(negedge clk); rst_n = 1'b1; ready = 1'b1;
        exp_q.push_back(8'h3C);
        send_word(8'h3C, ^8'h3C, 1'b1, 1'b0, 1'b0);
        check_out("after_rst_3c");
        check("after_rst_valid", {31'h0, valid0}, 32'h1);
        @(negedge clk);

        // Parity: a good parity bit, then a bad one.
        send_word(8'h4D, 1'b0, 1'b1, 1'b0, 1'b0);
        check("par_ok", {31'h0, par0}, 32'h0);
        @(negedge clk);
        exp_q.push_back(8'h4D);
        send_word(8'h4D, 1'b1, 1'b1, 1'b0, 1'b0);
        check_out("par_bad_dat");
        check("par_bad_flag", {31'h0, par0}, {31'h0, PAR});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
